// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: MEM stage of a scalar pipeline with a multi-cycle data memory.
//
// An operation from EX that neither loads nor stores completes at the next
// clock edge. A load or store with WAIT>0 is captured, holds the stage busy
// (stall_out) for WAIT cycles, and completes on the edge where the wait
// counter reaches 1. Results are registered toward WB and the PC.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid             operation presented this cycle
//   write_reg, mem_to_reg, write_mem, mem_read, branch, zero   control from EX
//   size                 00 byte, 01 half, 10/11 word
//   sign_ext             1 sign-extends sub-word loads
//   pcplusimm            branch target
//   alu_result           ALU result, also the byte address
//   store_data           store data
//   reg_w                destination register index
//   stall_out            stage busy; upstream holds its inputs
//   out_valid, write_reg_out, mem_to_reg_out, spc_out, misalign_out
//   pcplusimm_out, load_data, alu_result_out, reg_w_out
module mem_stage_pipe #(
  parameter int DW   = 32,
  parameter int AW   = 8,
  parameter int RW   = 5,
  parameter int WAIT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          write_reg,
  input  logic          mem_to_reg,
  input  logic          write_mem,
  input  logic          mem_read,
  input  logic          branch,
  input  logic          zero,
  input  logic [1:0]    size,
  input  logic          sign_ext,
  input  logic [DW-1:0] pcplusimm,
  input  logic [DW-1:0] alu_result,
  input  logic [DW-1:0] store_data,
  input  logic [RW-1:0] reg_w,
  output logic          stall_out,
  output logic          out_valid,
  output logic          write_reg_out,
  output logic          mem_to_reg_out,
  output logic          spc_out,
  output logic          misalign_out,
  output logic [DW-1:0] pcplusimm_out,
  output logic [DW-1:0] load_data,
  output logic [DW-1:0] alu_result_out,
  output logic [RW-1:0] reg_w_out
);

  localparam logic [2:0] WAIT_C = 3'(WAIT);
  localparam bit         SLOW   = (WAIT != 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [2:0] cnt;

  logic [DW-1:0] mem [2**AW];

  // Sub-word load extension.
  function automatic logic [DW-1:0] ext8(input logic [7:0] b, input logic sx);
    logic signed [DW-1:0] r;
    r = sx ? {{(DW-8){b[7]}}, b} : {{(DW-8){1'b0}}, b};
    return r;
  endfunction

  function automatic logic [DW-1:0] ext16(input logic [15:0] h, input logic sx);
    logic signed [DW-1:0] r;
    r = sx ? {{(DW-16){h[15]}}, h} : {{(DW-16){1'b0}}, h};
    return r;
  endfunction

  function automatic logic [DW-1:0] load_ext(input logic [DW-1:0] w, input logic [1:0] lane,
                                             input logic [1:0] sz, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   return ext8(b, sx);
      2'b01:   return ext16(h, sx);
      default: return w;
    endcase
  endfunction

  // Stage 0: operation captured for a multi-cycle access.
  logic          wr_p0, m2r_p0, wm_p0, mr_p0, br_p0, z_p0, sx_p0;
  logic [1:0]    sz_p0;
  logic [DW-1:0] pc_p0, alu_p0, sd_p0;
  logic [RW-1:0] rw_p0;

  logic is_mem_in, accept_slow, done;
  assign is_mem_in   = write_mem | mem_read;
  assign accept_slow = (state == IDLE) && in_valid && is_mem_in && SLOW;
  assign done        = ((state == IDLE) && in_valid && !(is_mem_in && SLOW)) ||
                       ((state == BUSY) && (cnt == 3'd1));
  assign stall_out   = (state == BUSY);

  always_ff @(posedge clk) begin
    if (accept_slow) begin
      wr_p0  <= write_reg;
      m2r_p0 <= mem_to_reg;
      wm_p0  <= write_mem;
      mr_p0  <= mem_read;
      br_p0  <= branch;
      z_p0   <= zero;
      sx_p0  <= sign_ext;
      sz_p0  <= size;
      pc_p0  <= pcplusimm;
      alu_p0 <= alu_result;
      sd_p0  <= store_data;
      rw_p0  <= reg_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (accept_slow) begin
          state <= BUSY;
          cnt   <= WAIT_C;
        end
        BUSY: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operation being completed: live inputs in IDLE, captured copy in BUSY.
  logic          s_wr, s_m2r, s_wm, s_mr, s_br, s_z, s_sx;
  logic [1:0]    s_sz;
  logic [DW-1:0] s_pc, s_alu, s_sd;
  logic [RW-1:0] s_rw;

  always_comb begin
    s_wr  = write_reg;  s_m2r = mem_to_reg; s_wm = write_mem; s_mr = mem_read;
    s_br  = branch;     s_z   = zero;       s_sx = sign_ext;  s_sz = size;
    s_pc  = pcplusimm;  s_alu = alu_result; s_sd = store_data; s_rw = reg_w;
    if (state == BUSY) begin
      s_wr  = wr_p0;  s_m2r = m2r_p0; s_wm = wm_p0;  s_mr = mr_p0;
      s_br  = br_p0;  s_z   = z_p0;   s_sx = sx_p0;  s_sz = sz_p0;
      s_pc  = pc_p0;  s_alu = alu_p0; s_sd = sd_p0;  s_rw = rw_p0;
    end
  end

  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic          mis, do_store, do_load;
  logic [3:0]    be;
  logic [31:0]   wlane;

  assign widx     = s_alu[AW+1:2];
  assign lane     = s_alu[1:0];
  assign mis      = (s_wm | s_mr) &
                    (((s_sz == 2'b01) & lane[0]) | (s_sz[1] & (lane != 2'b00)));
  // A combined read+write request behaves as a store.
  assign do_store = done & s_wm & ~mis;
  assign do_load  = s_mr & ~s_wm & ~mis;

  always_comb begin
    be    = 4'b0000;
    wlane = s_sd[31:0];
    case (s_sz)
      2'b00: begin
        be            = 4'b0001 << lane;
        wlane         = {4{s_sd[7:0]}};
      end
      2'b01: begin
        be            = lane[1] ? 4'b1100 : 4'b0011;
        wlane         = {2{s_sd[15:0]}};
      end
      default: be     = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_store) begin
      if (s_sz[1]) begin
        mem[widx] <= s_sd;
      end else begin
        for (int l = 0; l < 4; l++)
          if (be[l]) mem[widx][8*l +: 8] <= wlane[8*l +: 8];
      end
    end
  end

  // Stage 1: registered results toward WB and PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      write_reg_out  <= 1'b0;
      mem_to_reg_out <= 1'b0;
      spc_out        <= 1'b0;
      misalign_out   <= 1'b0;
      pcplusimm_out  <= '0;
      load_data      <= '0;
      alu_result_out <= '0;
      reg_w_out      <= '0;
    end else begin
      out_valid      <= done;
      write_reg_out  <= done & s_wr & ~mis;
      mem_to_reg_out <= done & s_m2r;
      spc_out        <= done & s_br & s_z;
      if (done) begin
        misalign_out   <= mis;
        pcplusimm_out  <= s_pc;
        alu_result_out <= s_alu;
        reg_w_out      <= s_rw;
        load_data      <= do_load ? load_ext(mem[widx], lane, s_sz, s_sx) : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_pipe.sv
module tb_mem_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        write_reg = 1'b0, mem_to_reg = 1'b0, write_mem = 1'b0, mem_read = 1'b0;
  logic        branch = 1'b0, zero = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] pcplusimm = '0, alu_result = '0, store_data = '0;
  logic [4:0]  reg_w = '0;
  logic        stall_out, out_valid, write_reg_out, mem_to_reg_out, spc_out, misalign_out;
  logic [31:0] pcplusimm_out, load_data, alu_result_out;
  logic [4:0]  reg_w_out;

  mem_stage_pipe #(.DW(32), .AW(8), .RW(5), .WAIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .write_reg(write_reg), .mem_to_reg(mem_to_reg), .write_mem(write_mem),
    .mem_read(mem_read), .branch(branch), .zero(zero), .size(size),
    .sign_ext(sign_ext), .pcplusimm(pcplusimm), .alu_result(alu_result),
    .store_data(store_data), .reg_w(reg_w), .stall_out(stall_out),
    .out_valid(out_valid), .write_reg_out(write_reg_out),
    .mem_to_reg_out(mem_to_reg_out), .spc_out(spc_out),
    .misalign_out(misalign_out), .pcplusimm_out(pcplusimm_out),
    .load_data(load_data), .alu_result_out(alu_result_out), .reg_w_out(reg_w_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr, m2r, wm, mr, br, z;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] pc, alu, sd;
    logic [4:0]  rw;
  } op_t;

  typedef struct packed {
    logic        wr, m2r, spc, mis;
    logic [31:0] pc, ld, alu;
    logic [4:0]  rw;
  } exp_t;

  exp_t       sb[$];
  exp_t       got_r, e;
  logic [7:0] ref_mem [0:1023];
  int         tests = 0, failed = 0, stall_cnt;
  bit         timed_out;

  // Byte-addressed little-endian reference memory and result model.
  function automatic exp_t model(input op_t o);
    exp_t r;
    int a, nb;
    logic [31:0] v;
    bit mis;
    a   = int'(o.alu[9:0]);
    nb  = (o.sz == 2'b00) ? 1 : (o.sz == 2'b01) ? 2 : 4;
    mis = (o.wm || o.mr) && (a % nb != 0);
    r.wr = o.wr && !mis; r.m2r = o.m2r; r.spc = o.br && o.z; r.mis = mis;
    r.pc = o.pc; r.alu = o.alu; r.rw = o.rw; r.ld = '0;
    if (o.wm && !mis) begin
      for (int i = 0; i < nb; i++) ref_mem[a+i] = o.sd[8*i +: 8];
    end else if (o.mr && !o.wm && !mis) begin
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[a+i];
      if (o.sx && v[8*nb-1]) for (int k = 8*nb; k < 32; k++) v[k] = 1'b1;
      r.ld = v;
    end
    return r;
  endfunction

  function automatic op_t mkop(input logic wm, input logic mr, input logic [1:0] sz,
                               input logic sx, input logic [31:0] alu,
                               input logic [31:0] sd, input logic wr);
    op_t o;
    o = '0;
    o.wm = wm; o.mr = mr; o.sz = sz; o.sx = sx; o.alu = alu; o.sd = sd;
    o.wr = wr; o.m2r = mr; o.rw = 5'(alu[4:0] + 5'd1); o.pc = alu + 32'h100;
    return o;
  endfunction

  task automatic drive(input op_t o);
    write_reg = o.wr; mem_to_reg = o.m2r; write_mem = o.wm; mem_read = o.mr;
    branch = o.br; zero = o.z; size = o.sz; sign_ext = o.sx;
    pcplusimm = o.pc; alu_result = o.alu; store_data = o.sd; reg_w = o.rw;
    in_valid = 1'b1;
  endtask

  task automatic do_op(input op_t o);
    bit got;
    sb.push_back(model(o));
    @(negedge clk);
    drive(o);
    got = 0; stall_cnt = 0; got_r = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        got = 1;
        got_r = {write_reg_out, mem_to_reg_out, spc_out, misalign_out,
                 pcplusimm_out, load_data, alu_result_out, reg_w_out};
      end else begin
        in_valid = 1'b0;
        if (stall_out) stall_cnt++;
      end
    end
    in_valid = 1'b0;
    timed_out = !got;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (stall_out !== 1'b0 || out_valid !== 1'b0) begin
      failed++; $display("FAIL reset_ctl: stall=%b valid=%b want 0 0", stall_out, out_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({write_reg_out, mem_to_reg_out, spc_out, misalign_out, pcplusimm_out,
         load_data, alu_result_out, reg_w_out} !== '0) begin
      failed++; $display("FAIL reset_out: got %h %h %h want 0", pcplusimm_out, load_data, alu_result_out);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_alu;
    op_t o;
    o = mkop(0, 0, 2'b10, 0, 32'h1234, 32'h0, 1);
    o.rw = 5'd7;
    do_op(o);
    e = sb.pop_front();
    tests++;
    if (timed_out || got_r !== e) begin
      failed++; $display("FAIL alu_op: got %h want %h", got_r, e);
    end
    tests++;
    if (stall_cnt != 0) begin
      failed++; $display("FAIL alu_stall: got %0d want 0", stall_cnt);
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || write_reg_out !== 1'b0 || alu_result_out !== 32'h1234) begin
      failed++; $display("FAIL alu_after: valid=%b wr=%b alu=%h want 0 0 1234", out_valid, write_reg_out, alu_result_out);
    end
  endtask

  task automatic test_store_load;
    op_t ops[6];
    string nm[6];
    ops[0] = mkop(1, 0, 2'b10, 0, 32'h10, 32'hA1B2C3D4, 0); nm[0] = "st_word";
    ops[1] = mkop(0, 1, 2'b00, 1, 32'h13, 32'h0, 1);        nm[1] = "ld_byte_sx";
    ops[2] = mkop(0, 1, 2'b00, 0, 32'h13, 32'h0, 1);        nm[2] = "ld_byte_zx";
    ops[3] = mkop(1, 0, 2'b01, 0, 32'h12, 32'h00007F80, 0); nm[3] = "st_half";
    ops[4] = mkop(0, 1, 2'b10, 0, 32'hFFFFFC10, 32'h0, 1);  nm[4] = "ld_word_hiaddr";
    ops[5] = mkop(0, 1, 2'b00, 1, 32'h12, 32'h0, 1);        nm[5] = "ld_byte_80";
    for (int i = 0; i < 6; i++) begin
      do_op(ops[i]);
      e = sb.pop_front();
      tests++;
      if (timed_out || got_r !== e) begin
        failed++; $display("FAIL %s: got %h want %h", nm[i], got_r, e);
      end
      tests++;
      if (stall_cnt != 2) begin
        failed++; $display("FAIL %s_stall: got %0d want 2", nm[i], stall_cnt);
      end
    end
  endtask

  task automatic test_misalign;
    op_t ops[4];
    string nm[4];
    ops[0] = mkop(0, 1, 2'b10, 0, 32'h11, 32'h0, 1);        nm[0] = "mis_ld_word";
    ops[1] = mkop(1, 0, 2'b10, 0, 32'h11, 32'hDEADBEEF, 0); nm[1] = "mis_st_word";
    ops[2] = mkop(0, 1, 2'b01, 1, 32'h13, 32'h0, 1);        nm[2] = "mis_ld_half";
    ops[3] = mkop(0, 1, 2'b10, 0, 32'h10, 32'h0, 1);        nm[3] = "mis_unchanged";
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i]);
      e = sb.pop_front();
      tests++;
      if (timed_out || got_r !== e) begin
        failed++; $display("FAIL %s: got %h want %h", nm[i], got_r, e);
      end
    end
  endtask

  task automatic test_branch;
    op_t o;
    o = mkop(0, 0, 2'b10, 0, 32'h8, 32'h0, 0);
    o.br = 1; o.z = 1; o.pc = 32'h40;
    do_op(o);
    e = sb.pop_front();
    tests++;
    if (timed_out || got_r !== e) begin
      failed++; $display("FAIL branch_taken: got %h want %h", got_r, e);
    end
    @(posedge clk); #1;
    tests++;
    if (spc_out !== 1'b0 || pcplusimm_out !== 32'h40) begin
      failed++; $display("FAIL branch_pulse: spc=%b pc=%h want 0 40", spc_out, pcplusimm_out);
    end
    o.z = 0; o.pc = 32'h80;
    do_op(o);
    e = sb.pop_front();
    tests++;
    if (timed_out || got_r !== e) begin
      failed++; $display("FAIL branch_not_taken: got %h want %h", got_r, e);
    end
  endtask

  task automatic test_rw_both;
    op_t o;
    o = mkop(1, 1, 2'b10, 0, 32'h30, 32'hCAFEF00D, 1);
    do_op(o);
    e = sb.pop_front();
    tests++;
    if (timed_out || got_r !== e) begin
      failed++; $display("FAIL both_store: got %h want %h", got_r, e);
    end
    do_op(mkop(0, 1, 2'b10, 0, 32'h30, 32'h0, 1));
    e = sb.pop_front();
    tests++;
    if (timed_out || got_r !== e) begin
      failed++; $display("FAIL both_readback: got %h want %h", got_r, e);
    end
  endtask

  task automatic test_reset_busy;
    do_op(mkop(1, 0, 2'b00, 0, 32'h20, 32'h11, 0));
    e = sb.pop_front();
    tests++;
    if (timed_out || got_r !== e) begin
      failed++; $display("FAIL prior_store: got %h want %h", got_r, e);
    end
    @(negedge clk);
    drive(mkop(1, 0, 2'b00, 0, 32'h20, 32'h55, 1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++;
    if (stall_out !== 1'b1) begin
      failed++; $display("FAIL abort_busy: stall=%b want 1", stall_out);
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (stall_out !== 1'b0 ||
        {out_valid, write_reg_out, mem_to_reg_out, spc_out, misalign_out, pcplusimm_out,
         load_data, alu_result_out, reg_w_out} !== '0) begin
      failed++; $display("FAIL abort_reset: stall=%b alu=%h pc=%h want all 0", stall_out, alu_result_out, pcplusimm_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op(mkop(0, 1, 2'b00, 0, 32'h20, 32'h0, 1));
    e = sb.pop_front();
    tests++;
    if (timed_out || got_r !== e) begin
      failed++; $display("FAIL abort_mem_kept: got %h want %h", got_r, e);
    end
  endtask

  task automatic test_back_to_back;
    op_t o;
    for (int i = 0; i < 4; i++) begin
      o = mkop(0, 0, 2'b10, 0, $urandom, 32'h0, 1'($urandom_range(0, 1)));
      o.m2r = 1'($urandom_range(0, 1));
      o.br = 1'b1; o.z = 1'($urandom_range(0, 1));
      o.pc = $urandom; o.rw = 5'($urandom_range(0, 31));
      do_op(o);
      e = sb.pop_front();
      tests++;
      if (timed_out || got_r !== e || stall_cnt != 0) begin
        failed++; $display("FAIL b2b_%0d: got %h want %h stall %0d", i, got_r, e, stall_cnt);
      end
    end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_store_load;
    test_misalign;
    test_branch;
    test_rw_both;
    test_reset_busy;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
